wbu_char_serializer: RTL and testbench

Downstream consumer of the 36-bit codeword synchronous FIFO on the JTAG/UART-to-wishbone return path. It pops one codeword at a time, splits it into six 6-bit digits, maps each digit to a printable ASCII character, and emits the characters one per handshake to the byte transmitter. A newline follows each codeword unless another codeword is already waiting. A programmable idle codeword is sent when the link has been quiet too long.

---
 rtl/wbu_char_serializer.sv | 140 ++++++++++++++
 tb/tb_wbu_char_serializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_char_serializer.sv
// ============================================================================
// Module      : wbu_char_serializer
// Description : Pops 36-bit codewords and emits them as six printable ASCII
//               digits, with a newline at burst end and an idle keep-alive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbu_char_serializer #(
  parameter int          LGIDLE    = 22,
  parameter logic [35:0] IDLE_WORD = 36'h0_0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic [35:0] i_codword,
  output logic        o_rd,
  output logic        o_stb,
  output logic [7:0]  o_byte,
  input  logic        i_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_NL   = 2'd2
  } state_t;

  localparam logic [LGIDLE-1:0] c_IDLE_ONE  = LGIDLE'(1);
  localparam logic [LGIDLE-1:0] c_IDLE_MAX  = '1;
  localparam logic [LGIDLE-1:0] c_IDLE_LAST = c_IDLE_MAX - c_IDLE_ONE;

  state_t            state_q, state_d;
  logic [35:0]       sreg_q, sreg_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [LGIDLE-1:0] idle_q, idle_d;
  logic              stb_q, stb_d;
  logic [7:0]        byte_q, byte_d;

  logic              w_accept;
  logic              w_ready;
  logic              w_load;
  logic [35:0]       w_word;

  function automatic logic [7:0] f_map(input logic [5:0] d);
    logic [7:0] r;
    if (d < 6'd10)      r = 8'h30 + {2'b00, d};
    else if (d < 6'd36) r = 8'h37 + {2'b00, d};
    else if (d < 6'd62) r = 8'h3D + {2'b00, d};
    else if (d == 6'd62) r = 8'h40;
    else                 r = 8'h25;
    return r;
  endfunction

  assign w_accept = stb_q & ~i_busy;
  // The FIFO may be popped in IDLE or as the last digit of a word leaves.
  assign w_ready  = (state_q == S_IDLE) ||
                    ((state_q == S_SEND) && w_accept && (cnt_q == 3'd5));
  assign o_rd     = w_ready & i_stb & ~i_rst;
  assign o_stb    = stb_q;
  assign o_byte   = byte_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    stb_d   = stb_q;
    byte_d  = byte_q;
    w_load  = 1'b0;
    w_word  = i_codword;

    case (state_q)
      S_IDLE: begin
        if (i_stb) begin
          w_load = 1'b1;
        end else if (idle_q == c_IDLE_LAST) begin
          w_load = 1'b1;
          w_word = IDLE_WORD;
        end else if (idle_q != c_IDLE_MAX) begin
          idle_d = idle_q + c_IDLE_ONE;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          if (cnt_q != 3'd5) begin
            sreg_d = {sreg_q[29:0], 6'b0};
            cnt_d  = cnt_q + 3'd1;
            byte_d = f_map(sreg_q[29:24]);
          end else if (i_stb) begin
            w_load = 1'b1;
          end else begin
            state_d = S_NL;
            byte_d  = 8'h0A;
          end
        end
      end
      S_NL: begin
        if (w_accept) begin
          state_d = S_IDLE;
          stb_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        stb_d   = 1'b0;
      end
    endcase

    if (w_load) begin
      state_d = S_SEND;
      sreg_d  = w_word;
      cnt_d   = 3'd0;
      idle_d  = '0;
      stb_d   = 1'b1;
      byte_d  = f_map(w_word[35:30]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      stb_q   <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      stb_q   <= stb_d;
      byte_q  <= byte_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wbu_char_serializer.sv
// ============================================================================
// Module      : tb_wbu_char_serializer
// Description : Directed self-checking bench for wbu_char_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wbu_char_serializer;

  logic        i_clk;
  logic        i_rst;
  logic        i_stb;
  logic [35:0] i_codword;
  logic        o_rd;
  logic        o_stb;
  logic [7:0]  o_byte;
  logic        i_busy;

  int n_vec;
  int n_err;
  int rd_cnt;
  int acc_cnt;

  wbu_char_serializer #(
    .LGIDLE    (4),
    .IDLE_WORD (36'h0_0000_0000)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_stb     (i_stb),
    .i_codword (i_codword),
    .o_rd      (o_rd),
    .o_stb     (o_stb),
    .o_byte    (o_byte),
    .i_busy    (i_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_rd === 1'b1) rd_cnt++;
    if (o_stb === 1'b1 && i_busy === 1'b0) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst  = 1'b1;
    i_stb  = 1'b0;
    i_busy = 1'b0;
    tick();
    tick();
    i_rst  = 1'b0;
  endtask

  // Sends one isolated word with no backpressure and checks its characters.
  task automatic word_nb(input string tag, input logic [35:0] cw, input logic [47:0] exp);
    i_stb     = 1'b1;
    i_codword = cw;
    @(negedge i_clk);
    chk({tag, "_rd"}, {15'd0, o_rd}, 16'd1);
    tick();
    i_stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk({tag, "_char"}, {7'd0, o_stb, o_byte}, {7'd0, 1'b1, exp[47-8*i -: 8]});
      tick();
    end
    @(negedge i_clk);
    chk({tag, "_nl"}, {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h0A});
    tick();
    @(negedge i_clk);
    chk({tag, "_gap"}, {15'd0, o_stb}, 16'd0);
  endtask

  // Counts quiet cycles (o_stb low) up to a bound, starting at the current cycle.
  task automatic count_quiet(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_stb === 1'b1) break;
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int a0;
    int q;
    n_vec = 0; n_err = 0; rd_cnt = 0; acc_cnt = 0;
    i_rst = 1'b1; i_stb = 1'b1; i_busy = 1'b0; i_codword = 36'h041041041;

    // reset state, including no pop while reset is held with a word waiting
    tick();
    @(negedge i_clk);
    chk("rst_rd", {15'd0, o_rd}, 16'd0);
    chk("rst_out", {7'd0, o_stb, o_byte}, 16'd0);
    do_reset();

    // single word, all digits 1
    r0 = rd_cnt;
    word_nb("t1", 36'h041041041, {6{8'h31}});
    tick();
    chk("t1_rdcnt", 16'(rd_cnt - r0), 16'd1);

    // digit-map boundaries 9, 10, 35, 36, 61, 62
    do_reset();
    word_nb("t7", 36'h24A8E4F7E, {8'h39, 8'h41, 8'h5A, 8'h61, 8'h7A, 8'h40});

    // backpressure: busy alternates 1,0; output must hold while busy
    do_reset();
    r0 = rd_cnt; a0 = acc_cnt;
    i_stb = 1'b1; i_codword = 36'hFFFFFFFFF; i_busy = 1'b1;
    @(negedge i_clk);
    chk("t2_rd", {15'd0, o_rd}, 16'd1);
    tick();
    i_stb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      i_busy = 1'b1;
      @(negedge i_clk);
      chk("t2_hold", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, (i == 6) ? 8'h0A : 8'h25});
      tick();
      i_busy = 1'b0;
      @(negedge i_clk);
      chk("t2_take", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, (i == 6) ? 8'h0A : 8'h25});
      tick();
    end
    @(negedge i_clk);
    chk("t2_end", {15'd0, o_stb}, 16'd0);
    tick();
    chk("t2_acc", 16'(acc_cnt - a0), 16'd7);
    chk("t2_rdcnt", 16'(rd_cnt - r0), 16'd1);

    // two queued words: no newline between, second pop on sixth char
    do_reset();
    r0 = rd_cnt;
    i_stb = 1'b1; i_codword = 36'h0;
    @(negedge i_clk);
    chk("t3_rd_first", {15'd0, o_rd}, 16'd1);
    tick();
    i_codword = 36'h041041041;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("t3_w0", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h30});
      if (i == 5) chk("t3_rd_join", {15'd0, o_rd}, 16'd1);
      tick();
    end
    i_stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("t3_w1", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h31});
      tick();
    end
    @(negedge i_clk);
    chk("t3_nl", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h0A});
    tick();
    @(negedge i_clk);
    chk("t3_end", {15'd0, o_stb}, 16'd0);
    tick();
    chk("t3_rdcnt", 16'(rd_cnt - r0), 16'd2);

    // idle timeout: 15 quiet cycles, then the idle word, repeating
    do_reset();
    r0 = rd_cnt;
    count_quiet(q);
    chk("t4_quiet1", 16'(q), 16'd15);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge i_clk);
      chk("t4_idle", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h30});
      tick();
    end
    @(negedge i_clk);
    chk("t4_nl", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h0A});
    tick();
    count_quiet(q);
    chk("t4_quiet2", 16'(q), 16'd15);
    chk("t4_rdcnt", 16'(rd_cnt - r0), 16'd0);

    // reset during the third digit discards the word
    do_reset();
    i_stb = 1'b1; i_codword = 36'h041041041;
    tick();
    i_stb = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("t5_third", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h31});
    tick();
    i_rst = 1'b0;
    count_quiet(q);
    chk("t5_quiet", 16'(q), 16'd15);
    chk("t5_noresume", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h30});

    // word arriving during newline waits for IDLE
    do_reset();
    r0 = rd_cnt;
    i_stb = 1'b1; i_codword = 36'h041041041;
    tick();
    i_stb = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    i_stb = 1'b1; i_codword = 36'hFFFFFFFFF;
    @(negedge i_clk);
    chk("t6_nl", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h0A});
    chk("t6_nl_rd", {15'd0, o_rd}, 16'd0);
    tick();
    @(negedge i_clk);
    chk("t6_gap", {15'd0, o_stb}, 16'd0);
    chk("t6_idle_rd", {15'd0, o_rd}, 16'd1);
    tick();
    i_stb = 1'b0;
    @(negedge i_clk);
    chk("t6_first", {7'd0, o_stb, o_byte}, {7'd0, 1'b1, 8'h25});
    tick();
    chk("t6_rdcnt", 16'(rd_cnt - r0), 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
